piso_serializer: RTL and testbench

- Parallel-in serial-out stage that directly feeds eight_bit_shift_reg. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, MSB first.
- The downstream SIPO shifts from q[0] toward q[7], so after a full frame its q equals the transmitted word.
- word_done marks the cycle in which the downstream parallel output holds the complete word.

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_bit_counter.sv | 18 +
 rtl/piso_serializer.sv | 69 ++++++
 tb/tb_piso_serializer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and frame-length helper for piso_serializer.
// PISO_PARITY_EN appends one even-parity bit to every frame.
package piso_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int DEFAULT_WIDTH = 8;
    function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: frame bit counter with clear, increment and is_last flag.
module piso_bit_counter #(
    parameter int FRAME_LEN = 8,
    parameter int CW = $clog2(FRAME_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          is_last
);
    assign is_last = cnt == CW'(FRAME_LEN - 1);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, MSB-first serial-out with word_done pulse.
// PISO_PARITY_EN adds a trailing even-parity bit (frame becomes WIDTH+1 cycles).
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done
);
    localparam int FL = frame_len(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);
    state_t state, state_d;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0] bit_cnt;
    logic is_last, accept, shifting;
    assign in_ready = state == IDLE || is_last;
    assign accept = in_valid && in_ready;
    assign shifting = state == SHIFT && !is_last;
    piso_bit_counter #(.FRAME_LEN(FL), .CW(CW)) u_cnt (
        .clk(clk), .rst(rst), .clr(accept), .inc(shifting), .cnt(bit_cnt), .is_last(is_last)
    );
    always_comb begin
        state_d = accept ? SHIFT : (state == SHIFT && is_last) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_d;
    end
    // shreg holds the bits still to be sent, next one at the MSB
`ifdef PISO_PARITY_EN
    logic par;
    always_ff @(posedge clk) begin
        if (rst) par <= 1'b0;
        else if (accept) par <= ^in_data;
    end
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= state == SHIFT && is_last;
            if (accept) begin
                shreg     <= {in_data[WIDTH-2:0], 1'b0};
                ser_out   <= in_data[WIDTH-1];
                ser_valid <= 1'b1;
            end else if (shifting) begin
                shreg   <= shreg << 1;
`ifdef PISO_PARITY_EN
                ser_out <= (bit_cnt == CW'(WIDTH - 1)) ? par : shreg[WIDTH-1];
`else
                ser_out <= shreg[WIDTH-1];
`endif
            end else if (state == SHIFT) begin
                ser_out   <= 1'b0;
                ser_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed self-checking bench with a downstream SIPO model.
module tb_piso_serializer;
    import piso_pkg::*;
    localparam int W = 8;
    localparam int FL = frame_len(W);
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, ser_out, ser_valid, word_done;
    logic [W-1:0] in_data = '0;
    logic [FL-1:0] q = '0;
    int checks = 0, errors = 0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_out(ser_out), .ser_valid(ser_valid), .word_done(word_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) q <= {q[FL-2:0], ser_out};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [W-1:0] w, input int b);
        return (b < W) ? w[W-1-b] : ^w;
    endfunction

    task automatic frame(input logic [W-1:0] w);
        in_data = w;
        in_valid = 1'b1;
        chk("rdy_before", in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < FL; b++) begin
            chk("bit", ser_out, exp_bit(w, b));
            chk("sv", ser_valid, 1);
            chk("wd_mid", word_done, 0);
            tick();
        end
        chk("wd", word_done, 1);
        chk("q", q[FL-1 -: W], w);
        chk("idle_so", ser_out, 0);
        chk("idle_sv", ser_valid, 0);
        tick();
        chk("wd_once", word_done, 0);
    endtask

    initial begin
        in_valid = 1'b1;
        in_data = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rdy", in_ready, 1);
            chk("rst_so", ser_out, 0);
            chk("rst_sv", ser_valid, 0);
            chk("rst_wd", word_done, 0);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_sv", ser_valid, 0);

        frame(8'hA5);

        in_data = 8'h3C;
        in_valid = 1'b1;
        tick();
        in_data = 8'hC3;
        for (int i = 0; i < 2 * FL; i++) begin
            chk("b2b_bit", ser_out, exp_bit(i < FL ? 8'h3C : 8'hC3, i % FL));
            chk("b2b_sv", ser_valid, 1);
            chk("b2b_rdy", in_ready, (i % FL) == FL - 1);
            if (i == FL) begin
                chk("b2b_wd1", word_done, 1);
                chk("b2b_q1", q[FL-1 -: W], 8'h3C);
                in_valid = 1'b0;
            end else chk("b2b_wd0", word_done, 0);
            tick();
        end
        chk("b2b_wd2", word_done, 1);
        chk("b2b_q2", q[FL-1 -: W], 8'hC3);
        chk("b2b_end_sv", ser_valid, 0);

        frame(8'hFF);
        for (int i = 0; i < 5; i++) begin
            chk("stall_so", ser_out, 0);
            chk("stall_sv", ser_valid, 0);
            chk("stall_rdy", in_ready, 1);
            tick();
        end
        frame(8'h5A);

        in_data = 8'h81;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_bit3", ser_out, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_so", ser_out, 0);
        chk("mid_rdy", in_ready, 1);
        chk("mid_sv", ser_valid, 0);
        for (int i = 0; i < FL + 2; i++) begin
            chk("mid_no_wd", word_done, 0);
            tick();
        end
        frame(8'h7E);

`ifdef PISO_PARITY_EN
        frame(8'h07);
        frame(8'h03);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
